// File: rtl/ram_arbiter.sv
// CPU/DMA arbiter for the shared single-port data RAM, with DMA burst locking and CPU starvation guard.
// Optional DMA write protection (only 0x00-0x03 writable by DMA) under `RAM_ARBITER_WRPROT_EN.
module ram_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    input  logic              dma_lock,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              wr_err
);

    typedef enum logic {S_IDLE, S_DMA_LOCKED} state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_starve_cnt, w_starve_nxt;
    logic               w_cpu_win, w_dma_win;
    logic               w_lock_hold;
    logic               w_dma_wr_blocked;
    logic               r_cpu_rd_pend, r_dma_rd_pend;
    logic [DATA_W-1:0]  r_cpu_rdata, r_dma_rdata;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Arbitration, next state and starvation counter
    always_comb begin
        w_cpu_win    = 1'b0;
        w_dma_win    = 1'b0;
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_lock_hold  = (r_state == S_DMA_LOCKED) && dma_lock;

        if (w_lock_hold) begin
            w_dma_win = dma_req;
        end else if (cpu_req && dma_req) begin
            if (r_starve_cnt >= STARVE_LIM) w_cpu_win = 1'b1;
            else                            w_dma_win = 1'b1;
        end else begin
            w_cpu_win = cpu_req;
            w_dma_win = dma_req;
        end

        cpu_gnt = w_cpu_win && !Rst;
        dma_gnt = w_dma_win && !Rst;

        case (r_state)
            S_IDLE:       if (dma_gnt && dma_lock) w_state_nxt = S_DMA_LOCKED;
            S_DMA_LOCKED: if (!dma_lock)           w_state_nxt = S_IDLE;
            default:                               w_state_nxt = S_IDLE;
        endcase

        if (cpu_gnt || !cpu_req)
            w_starve_nxt = '0;
        else if (dma_gnt && (r_state == S_IDLE) && (r_starve_cnt != 3'd7))
            w_starve_nxt = r_starve_cnt + 3'd1;
    end

`ifdef RAM_ARBITER_WRPROT_EN
    logic r_wr_err;

    // Only the RX buffer window 0x00-0x03 is DMA-writable
    assign w_dma_wr_blocked = dma_gnt && dma_we && (|dma_addr[ADDR_W-1:2]);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                   r_wr_err <= 1'b0;
        else if (w_dma_wr_blocked) r_wr_err <= 1'b1;
    end

    assign wr_err = r_wr_err;
`else
    assign w_dma_wr_blocked = 1'b0;
    assign wr_err           = 1'b0;
`endif

    always_comb begin
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (cpu_gnt) begin
            ram_cs    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (dma_gnt && !w_dma_wr_blocked) begin
            ram_cs    = 1'b1;
            ram_we    = dma_we;
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
        end
    end

    // Read data passes straight through in the return cycle and is held afterwards
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cpu_rd_pend <= 1'b0;
            r_dma_rd_pend <= 1'b0;
            r_cpu_rdata   <= '0;
            r_dma_rdata   <= '0;
        end else begin
            r_cpu_rd_pend <= cpu_gnt && !cpu_we;
            r_dma_rd_pend <= dma_gnt && !dma_we;
            if (r_cpu_rd_pend) r_cpu_rdata <= ram_rdata;
            if (r_dma_rd_pend) r_dma_rdata <= ram_rdata;
        end
    end

    assign cpu_rvalid = r_cpu_rd_pend;
    assign dma_rvalid = r_dma_rd_pend;
    assign cpu_rdata  = r_cpu_rd_pend ? ram_rdata : r_cpu_rdata;
    assign dma_rdata  = r_dma_rd_pend ? ram_rdata : r_dma_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: vector table, hand sequences (protection, reset mid-burst) and a randomized model check.
module tb_ram_arbiter;
    localparam int DW = 8, AW = 8, SMAX = 4;
`ifdef RAM_ARBITER_WRPROT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic          Clk = 1'b0, Rst = 1'b1;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_gnt, dma_rvalid, dma_lock;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          ram_cs, ram_we, wr_err;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    always #5 Clk = ~Clk;

    ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .Clk(Clk), .Rst(Rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .dma_lock(dma_lock),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .wr_err(wr_err)
    );

    // Synchronous single-port RAM
    logic [7:0] ram_mem [256];
    always @(posedge Clk) begin
        if (ram_cs) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    int total = 0, bad = 0;

    task automatic chk1(string nm, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0b want=%0b", nm, act, exp);
        end
    endtask

    task automatic chk8(string nm, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%02h want=%02h", nm, act, exp);
        end
    endtask

    task automatic drive(logic cr, logic cw, logic [7:0] ca, logic [7:0] cd,
                         logic dr, logic dw, logic [7:0] da, logic [7:0] dd, logic dl);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_lock = dl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    typedef struct {
        logic cr, cw; logic [7:0] ca, cd;
        logic dr, dw; logic [7:0] da, dd; logic dl;
        logic ecg, edg, ecv; logic [7:0] ecd; logic edv; logic [7:0] edd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic cr, logic cw, logic [7:0] ca, logic [7:0] cd,
                                logic dr, logic dw, logic [7:0] da, logic [7:0] dd, logic dl,
                                logic ecg, logic edg, logic ecv, logic [7:0] ecd,
                                logic edv, logic [7:0] edd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.dl = dl;
        v.ecg = ecg; v.edg = edg; v.ecv = ecv; v.ecd = ecd; v.edv = edv; v.edd = edd;
        return v;
    endfunction

    // Randomized reference model state
    logic [7:0] mmem [256];
    bit         mlock, mcrv, mdrv, merr;
    int         mstarve;
    logic [7:0] mcrd, mdrd;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'h00;
            mmem[i]    = 8'h00;
        end
        ram_rdata = 8'h00;

        // Table: CPU write/read, rotation DDDDC, locked burst, locked beyond STARVE_MAX
        tbl.push_back(mk(1'b1,1'b1,8'h40,8'h5A, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,8'h00));
        tbl.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,8'h00));
        tbl.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b1,8'h5A,1'b0,8'h00));
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(1'b1,1'b1,8'h50,8'hC0, 1'b1,1'b1,8'h60,8'hD0,1'b0,
                             (k % 5 == 4), (k % 5 != 4), 1'b0,8'h5A,1'b0,8'h00));
        tbl.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b1,1'b1,8'h00,8'h11,1'b1, 1'b0,1'b1,1'b0,8'h5A,1'b0,8'h00));
        tbl.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b1,1'b1,8'h01,8'h22,1'b1, 1'b0,1'b1,1'b0,8'h5A,1'b0,8'h00));
        tbl.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b1,1'b1,8'h02,8'h33,1'b1, 1'b0,1'b1,1'b0,8'h5A,1'b0,8'h00));
        tbl.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b1,1'b1,8'h03,8'h01,1'b0, 1'b0,1'b1,1'b0,8'h5A,1'b0,8'h00));
        tbl.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b1,1'b0,1'b0,8'h5A,1'b0,8'h00));
        tbl.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b1,8'h5A,1'b0,8'h00));
        tbl.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h02,8'h00,1'b0, 1'b0,1'b1,1'b0,8'h5A,1'b0,8'h00));
        tbl.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h5A,1'b1,8'h33));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b1,1'b1,8'h01,8'h22,1'b1, 1'b0,1'b1,1'b0,8'h5A,1'b0,8'h33));
        tbl.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b1,1'b1,8'h01,8'h22,1'b0, 1'b0,1'b1,1'b0,8'h5A,1'b0,8'h33));
        tbl.push_back(mk(1'b1,1'b0,8'h40,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b1,1'b0,1'b0,8'h5A,1'b0,8'h33));
        tbl.push_back(mk(1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b1,8'h5A,1'b0,8'h33));

        // Reset state, with both requesters asserting
        drive(1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1);
        #12;
        chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
        chk1("rst_dma_gnt", dma_gnt, 1'b0);
        chk1("rst_ram_cs", ram_cs, 1'b0);
        chk1("rst_ram_we", ram_we, 1'b0);
        chk8("rst_ram_addr", ram_addr, 8'h00);
        chk8("rst_ram_wdata", ram_wdata, 8'h00);
        chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        chk1("rst_dma_rvalid", dma_rvalid, 1'b0);
        chk8("rst_cpu_rdata", cpu_rdata, 8'h00);
        chk8("rst_dma_rdata", dma_rdata, 8'h00);
        chk1("rst_wr_err", wr_err, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;
        idle();

        foreach (tbl[i]) begin
            @(negedge Clk);
            drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
                  tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd, tbl[i].dl);
            #1;
            chk1($sformatf("tbl%0d_cpu_gnt", i), cpu_gnt, tbl[i].ecg);
            chk1($sformatf("tbl%0d_dma_gnt", i), dma_gnt, tbl[i].edg);
            chk1($sformatf("tbl%0d_cpu_rvalid", i), cpu_rvalid, tbl[i].ecv);
            chk8($sformatf("tbl%0d_cpu_rdata", i), cpu_rdata, tbl[i].ecd);
            chk1($sformatf("tbl%0d_dma_rvalid", i), dma_rvalid, tbl[i].edv);
            chk8($sformatf("tbl%0d_dma_rdata", i), dma_rdata, tbl[i].edd);
        end

        // DMA write outside the RX buffer window
        @(negedge Clk);
        drive(1'b1, 1'b1, 8'h30, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #1 chk1("wp_cpu_wr_gnt", cpu_gnt, 1'b1);
        @(negedge Clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h30, 8'hFF, 1'b0);
        #1;
        chk1("wp_dma_gnt", dma_gnt, 1'b1);
        chk1("wp_ram_cs", ram_cs, !WP);
        chk1("wp_ram_we", ram_we, !WP);
        chk1("wp_err_before", wr_err, 1'b0);
        @(negedge Clk);
        drive(1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        chk1("wp_cpu_rd_gnt", cpu_gnt, 1'b1);
        chk1("wp_err_after", wr_err, WP);
        @(negedge Clk);
        idle();
        #1;
        chk1("wp_rvalid", cpu_rvalid, 1'b1);
        chk8("wp_rdata", cpu_rdata, WP ? 8'h77 : 8'hFF);
        chk1("wp_err_sticky", wr_err, WP);

        // Reset asserted asynchronously inside a locked burst with a read outstanding
        @(negedge Clk);
        drive(1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1);
        #1 chk1("lk_gnt1", dma_gnt, 1'b1);
        @(negedge Clk);
        drive(1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1);
        #1;
        chk1("lk_gnt2", dma_gnt, 1'b1);
        chk1("lk_rv1", dma_rvalid, 1'b1);
        chk8("lk_rd1", dma_rdata, 8'h22);
        #2 Rst = 1'b1;
        #1;
        chk1("arst_cpu_gnt", cpu_gnt, 1'b0);
        chk1("arst_dma_gnt", dma_gnt, 1'b0);
        chk1("arst_ram_cs", ram_cs, 1'b0);
        chk1("arst_dma_rvalid", dma_rvalid, 1'b0);
        chk8("arst_dma_rdata", dma_rdata, 8'h00);
        chk8("arst_cpu_rdata", cpu_rdata, 8'h00);
        chk1("arst_wr_err", wr_err, 1'b0);
        @(negedge Clk);
        #1;
        chk1("arst_hold_dma_gnt", dma_gnt, 1'b0);
        chk1("arst_hold_rvalid", dma_rvalid, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;
        drive(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        chk1("post_rst_cpu_gnt", cpu_gnt, 1'b1);
        chk1("post_rst_dma_rv", dma_rvalid, 1'b0);
        @(negedge Clk);
        idle();
        #1;
        chk1("post_rst_cpu_rv", cpu_rvalid, 1'b1);
        chk8("post_rst_cpu_rd", cpu_rdata, 8'h5A);
        chk1("post_rst_dma_rv2", dma_rvalid, 1'b0);

        // Randomized run against the reference model
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        mmem[0] = 8'h11; mmem[1] = 8'h22; mmem[2] = 8'h33; mmem[3] = 8'h01;
        mlock = 1'b0; mcrv = 1'b0; mdrv = 1'b0; merr = 1'b0; mstarve = 0;
        mcrd = 8'h00; mdrd = 8'h00;
        begin
            logic cr, cw, dr, dw, dl, c_won, d_won, blk, exp_cs, exp_we;
            logic [7:0] ca, cd, da, dd;
            int win, pick;
            cr = 1'b0; dr = 1'b0; c_won = 1'b0; d_won = 1'b0;
            cw = 1'b0; dw = 1'b0; ca = 8'h00; cd = 8'h00; da = 8'h00; dd = 8'h00;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                @(negedge Clk);
                // A pending request holds its fields until granted, or is occasionally abandoned
                if (!cr || c_won || $urandom_range(7) == 0) begin
                    cr = ($urandom_range(2) != 0);
                    cw = ($urandom_range(1) == 1);
                    pick = $urandom_range(7);
                    ca = (pick < 4) ? 8'(pick) : 8'(8'h80 + pick);
                    cd = 8'($urandom);
                end
                if (!dr || d_won || $urandom_range(7) == 0) begin
                    dr = ($urandom_range(2) != 0);
                    dw = ($urandom_range(1) == 1);
                    pick = $urandom_range(7);
                    da = (pick < 4) ? 8'(pick) : 8'(8'h80 + pick);
                    dd = 8'($urandom);
                end
                dl = ($urandom_range(2) == 0);
                drive(cr, cw, ca, cd, dr, dw, da, dd, dl);
                #1;

                // DMA has priority unless the CPU has already waited SMAX DMA grants; a held lock shuts out the CPU
                if (mlock && dl)        win = dr ? 2 : 0;
                else if (cr && dr)      win = (mstarve >= SMAX) ? 1 : 2;
                else if (cr)            win = 1;
                else if (dr)            win = 2;
                else                    win = 0;
                blk    = WP && (win == 2) && dw && (da > 8'h03);
                exp_cs = (win != 0) && !blk;
                exp_we = exp_cs && ((win == 1) ? cw : dw);

                chk1($sformatf("rnd%0d_cpu_gnt", cyc), cpu_gnt, win == 1);
                chk1($sformatf("rnd%0d_dma_gnt", cyc), dma_gnt, win == 2);
                chk1($sformatf("rnd%0d_ram_cs", cyc), ram_cs, exp_cs);
                chk1($sformatf("rnd%0d_ram_we", cyc), ram_we, exp_we);
                if (exp_cs)
                    chk8($sformatf("rnd%0d_ram_addr", cyc), ram_addr, (win == 1) ? ca : da);
                if (exp_we)
                    chk8($sformatf("rnd%0d_ram_wdata", cyc), ram_wdata, (win == 1) ? cd : dd);
                chk1($sformatf("rnd%0d_cpu_rv", cyc), cpu_rvalid, mcrv);
                chk8($sformatf("rnd%0d_cpu_rd", cyc), cpu_rdata, mcrd);
                chk1($sformatf("rnd%0d_dma_rv", cyc), dma_rvalid, mdrv);
                chk8($sformatf("rnd%0d_dma_rd", cyc), dma_rdata, mdrd);
                chk1($sformatf("rnd%0d_wr_err", cyc), wr_err, merr);

                mcrv = (win == 1) && !cw;
                mdrv = (win == 2) && !dw;
                if (mcrv) mcrd = mmem[ca];
                if (mdrv) mdrd = mmem[da];
                if (win == 1 && cw)         mmem[ca] = cd;
                if (win == 2 && dw && !blk) mmem[da] = dd;
                if (win == 1 || !cr)        mstarve = 0;
                else if (win == 2 && !mlock && mstarve < 7) mstarve++;
                mlock = mlock ? dl : ((win == 2) && dl);
                merr  = merr || blk;
                c_won = (win == 1);
                d_won = (win == 2);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
